// File: rtl/typedefs_pkg.sv
// Shared types for the LED sequencer: color codes, FSM states and
// small elaboration-time helpers.
package typedefs_pkg;

    localparam int LFSR_WIDTH = 16;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        IDLE,
        ON,
        GAP,
        FLASH_ON,
        FLASH_OFF
    } led_state_t;

    // Larger of two integers, used to size the shared cycle timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // LED pattern {yellow, blue, green, red} with only the given color lit.
    function automatic logic [3:0] led_onehot(input color_t c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter that stops at zero and flags it.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/led_sequencer.sv
// LED sequencer: shows one color for a speed-dependent time followed by a
// dark gap, or flashes all four LEDs a fixed number of times.
// Optional build macro LED_SEQ_ABORT_EN adds an 'abort' input that returns
// the sequencer to IDLE without a done pulse.
module led_sequencer
    import typedefs_pkg::*;
#(
    parameter int FAST_ON_CYC = 4,
    parameter int SLOW_ON_CYC = 8,
    parameter int GAP_CYC     = 2,
    parameter int FLASH_CYC   = 3,
    parameter int FLASH_REPS  = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   speed,
    input  color_t color,
    input  logic   show,
    input  logic   flash_all,
`ifdef LED_SEQ_ABORT_EN
    input  logic   abort,
`endif
    output logic   busy,
    output logic   done,
    output logic   led_red,
    output logic   led_green,
    output logic   led_blue,
    output logic   led_yellow
);

    localparam int TW = $clog2(max_int(max_int(max_int(FAST_ON_CYC, SLOW_ON_CYC),
                                               max_int(GAP_CYC, FLASH_CYC)),
                                       FLASH_REPS)) + 1;
    localparam int RW = $clog2(FLASH_REPS) + 1;

    // Timer reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [TW-1:0] FAST_LOAD  = TW'(FAST_ON_CYC - 1);
    localparam logic [TW-1:0] SLOW_LOAD  = TW'(SLOW_ON_CYC - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] FLASH_LOAD = TW'(FLASH_CYC - 1);
    localparam logic [RW-1:0] LAST_REP   = RW'(FLASH_REPS - 1);

    led_state_t    state, next_state;
    color_t        col_q, col_next;
    logic [RW-1:0] rep_cnt, rep_next;
    logic          timer_load;
    logic [TW-1:0] timer_val;
    logic          timer_zero;
    logic          finishing;
    logic [3:0]    led_q, led_next;
    logic          busy_next;

    down_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // State, latched color, flash repeat count and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            col_q   <= RED;
            rep_cnt <= '0;
            led_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= next_state;
            col_q   <= col_next;
            rep_cnt <= rep_next;
            led_q   <= led_next;
            busy    <= busy_next;
            done    <= finishing;
        end
    end

    // Next state and timer reloads; requests are only looked at in IDLE.
    always_comb begin
        next_state = state;
        col_next   = col_q;
        rep_next   = rep_cnt;
        timer_load = 1'b0;
        timer_val  = '0;
        finishing  = 1'b0;
        case (state)
            IDLE: begin
                if (flash_all) begin
                    next_state = FLASH_ON;
                    timer_load = 1'b1;
                    timer_val  = FLASH_LOAD;
                    rep_next   = '0;
                end else if (show) begin
                    next_state = ON;
                    timer_load = 1'b1;
                    timer_val  = speed ? FAST_LOAD : SLOW_LOAD;
                    col_next   = color;
                end
            end
            ON: begin
                if (timer_zero) begin
                    next_state = GAP;
                    timer_load = 1'b1;
                    timer_val  = GAP_LOAD;
                end
            end
            GAP: begin
                if (timer_zero) begin
                    next_state = IDLE;
                    finishing  = 1'b1;
                end
            end
            FLASH_ON: begin
                if (timer_zero) begin
                    next_state = FLASH_OFF;
                    timer_load = 1'b1;
                    timer_val  = FLASH_LOAD;
                end
            end
            FLASH_OFF: begin
                if (timer_zero) begin
                    if (rep_cnt == LAST_REP) begin
                        next_state = IDLE;
                        finishing  = 1'b1;
                    end else begin
                        next_state = FLASH_ON;
                        timer_load = 1'b1;
                        timer_val  = FLASH_LOAD;
                        rep_next   = rep_cnt + RW'(1);
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
`ifdef LED_SEQ_ABORT_EN
        if (abort) begin
            next_state = IDLE;
            col_next   = col_q;
            rep_next   = rep_cnt;
            timer_load = 1'b1;
            timer_val  = '0;
            finishing  = 1'b0;
        end
`endif
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        led_next  = '0;
        busy_next = (next_state != IDLE);
        case (next_state)
            ON:       led_next = led_onehot(col_next);
            FLASH_ON: led_next = 4'b1111;
            default:  led_next = '0;
        endcase
    end

    assign led_red    = led_q[0];
    assign led_green  = led_q[1];
    assign led_blue   = led_q[2];
    assign led_yellow = led_q[3];

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameters SHALL be: FAST_ON_CYC, default 4, LED on-time when speed=1. SLOW_ON_CYC, default 8, LED on-time when speed=0. GAP_CYC, default 2, all-off gap after each color. FLASH_CYC, default 3, on and off half-period of flash. FLASH_REPS, default 2, flash on/off pairs.
REQ-002 Port `clk`: input, 1 bit, the single clock; all state SHALL be updated on its rising edge.
REQ-003 Port `rst`: input, 1 bit; reset is asynchronous and active-high.
REQ-004 Port `speed`: input, 1 bit; 1=fast, 0=slow.
REQ-005 Port `color`: input, 2 bits; color code to display, of type color_t.
REQ-006 Port `show`: input, 1 bit; request to display `color` once.
REQ-007 Port `flash_all`: input, 1 bit; request to flash all four LEDs (fail/win indication).
REQ-008 Port `busy`: output, 1 bit; high while a display or flash is in progress.
REQ-009 Port `done`: output, 1 bit; one-cycle pulse when a display or flash completes.
REQ-010 Ports `led_red`, `led_green`, `led_blue`, `led_yellow`: outputs, 1 bit each, registered LED drives.

Function
REQ-011 The FSM SHALL have states IDLE, ON, GAP, FLASH_ON and FLASH_OFF; outputs are registered; the cycle timer width SHALL be $clog2 of the largest parameter plus 1.
REQ-012 A request SHALL be accepted only in IDLE, on the edge ending cycle T where show=1 or flash_all=1; `color` and `speed` SHALL be latched at acceptance.
REQ-013 Show sequence: ON for on_cyc cycles (T+1..T+on_cyc), selected LED only; then GAP for GAP_CYC cycles, all LEDs 0; done=1 in cycle T+on_cyc+GAP_CYC+1, state IDLE.
REQ-014 Color decode SHALL be: 0=red, 1=green, 2=blue, 3=yellow; exactly one LED high in ON.
REQ-015 Flash sequence: FLASH_ON (all four LEDs 1) for FLASH_CYC, then FLASH_OFF (all 0) for FLASH_CYC, repeated FLASH_REPS times; done=1 in cycle T+2*FLASH_CYC*FLASH_REPS+1.
REQ-016 `busy` SHALL be 1 in every non-IDLE cycle and 0 in IDLE, including the done cycle.
REQ-017 A new request asserted in the done cycle SHALL be accepted, giving back-to-back operation with no dead cycle.
REQ-018 Requests asserted while busy=1 SHALL be ignored and not queued.
REQ-019 If show and flash_all are both 1 at acceptance, flash SHALL win and show is dropped.
REQ-020 Changes on speed or color while busy SHALL have no effect on the current operation.

Reset
REQ-021 While rst=1, asynchronously: state=IDLE, timer=0, all LEDs=0, busy=0, done=0.
REQ-022 Reset mid-operation SHALL abort the operation with no done pulse; the first request is acceptable in the first cycle after rst falls.

Configuration
REQ-023 The macro LED_SEQ_ABORT_EN SHALL control an extra input port `abort` (1 bit).
REQ-024 With LED_SEQ_ABORT_EN defined, abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with LEDs 0, no done pulse, and busy=0.
REQ-025 With LED_SEQ_ABORT_EN defined, abort=1 in IDLE SHALL take priority over show and flash_all, so no request is accepted that cycle.
REQ-026 Without LED_SEQ_ABORT_EN, the `abort` port and its logic SHALL be absent.

Structure
REQ-027 color_t (2-bit enum RED, GREEN, BLUE, YELLOW) and led_state_t SHALL live in typedefs_pkg, next to LFSR_WIDTH.
REQ-028 One sub-module, down_timer (loadable down-counter with zero flag), is natural; it SHALL be instantiated once and reloaded per state.

Verification
REQ-029 Fast show: show=1, color=2, speed=1 at T -> led_blue=1 in T+1..T+4, all LEDs 0 in T+5..T+6, done=1 in T+7, busy=1 in T+1..T+6.
REQ-030 Slow show: color=0, speed=0 -> led_red=1 in T+1..T+8, done in T+11.
REQ-031 Flash: flash_all=1 at T -> all LEDs 1 in T+1..3 and T+7..9, 0 in T+4..6 and T+10..12, done in T+13.
REQ-032 Contention: show and flash_all both 1 -> flash pattern; show=1 at T+3 of a running show -> ignored, exactly one done; show held through the done cycle -> second sequence starts with LED on in done cycle+1.
REQ-033 Reset: rst=1 at T+2 of a show -> LEDs 0 immediately, no done; show in the cycle after rst falls -> accepted.
REQ-034 With LED_SEQ_ABORT_EN: abort=1 at T+3 of a flash -> all LEDs 0 and busy=0 from T+4, no done.
